// File: rtl/result_drain.sv
// result_drain: captures finished 2x2 result tiles from the systolic array
// into a two-slot ping-pong buffer and streams them to the host one byte at
// a time, either as raw 16-bit little-endian words or saturated to int8.
//
// Handshakes:
//   capture side: a tile is accepted on a rising edge where cap_valid and
//   cap_ready are both high. cap_valid while cap_ready is low drops the tile
//   and sets the sticky overflow flag.
//   host side: out_data/out_last are meaningful while out_valid is high; a
//   byte is consumed on a rising edge where host_ack and out_valid are both
//   high. host_ack with out_valid low has no effect.
module result_drain #(
  parameter int SLOTS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cap_valid,
  input  logic [15:0] c00,
  input  logic [15:0] c01,
  input  logic [15:0] c10,
  input  logic [15:0] c11,
  input  logic        mode,
  output logic        cap_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        host_ack,
  output logic        overflow,
  input  logic        clear_err
);

  // Occupancy value at which both slots are in use.
  localparam logic [1:0] FULL_COUNT = 2'(SLOTS);

  // Tile storage; contents are don't-care until written, so not reset.
  logic [15:0] slot_data [2][4];
  logic        slot_mode [2];

  logic       wp;
  logic       rp;
  logic [1:0] count;
  logic [2:0] bi;
  logic       overflow_q;

  logic       cap_fire;
  logic       cap_drop;
  logic       ack_fire;
  logic       pop;
  logic       head_mode;
  logic [2:0] last_bi;
  logic [15:0] head_word;

  // Clamp a signed 16-bit accumulation into the int8 range.
  function automatic logic [7:0] sat8(input logic signed [15:0] x);
    logic [7:0] r;
    if (x > 16'sd127)       r = 8'h7F;
    else if (x < -16'sd128) r = 8'h80;
    else                    r = x[7:0];
    return r;
  endfunction

  // Handshake qualifiers and head-tile decode, all from registered state.
  always_comb begin
    cap_ready = (count < FULL_COUNT);
    out_valid = (count != 2'd0);
    cap_fire  = cap_valid && cap_ready;
    cap_drop  = cap_valid && !cap_ready;
    head_mode = slot_mode[rp];
    last_bi   = head_mode ? 3'd3 : 3'd7;
    out_last  = out_valid && (bi == last_bi);
    ack_fire  = host_ack && out_valid;
    pop       = ack_fire && out_last;
  end

  // Byte mux: raw mode walks lo/hi of each word, int8 mode one word per byte.
  always_comb begin
    out_data  = 8'h00;
    head_word = slot_data[rp][bi[2:1]];
    if (out_valid) begin
      if (head_mode) begin
        out_data = sat8(slot_data[rp][bi[1:0]]);
      end else begin
        out_data = bi[0] ? head_word[15:8] : head_word[7:0];
      end
    end
  end

  // Store an accepted tile and its output mode into the write slot.
  always_ff @(posedge clk) begin
    if (cap_fire) begin
      slot_data[wp][0] <= c00;
      slot_data[wp][1] <= c01;
      slot_data[wp][2] <= c10;
      slot_data[wp][3] <= c11;
      slot_mode[wp]    <= mode;
    end
  end

  // Pointer, occupancy and byte-index bookkeeping; capture and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
      bi    <= 3'd0;
    end else begin
      if (cap_fire) wp <= ~wp;
      if (pop) begin
        rp <= ~rp;
        bi <= 3'd0;
      end else if (ack_fire) begin
        bi <= bi + 3'd1;
      end
      case ({cap_fire, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as clear_err keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (cap_drop) begin
      overflow_q <= 1'b1;
    end else if (clear_err) begin
      overflow_q <= 1'b0;
    end
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: raw and saturated tiles, back-to-back
// drain, overflow drop, simultaneous capture/pop, and reset mid-drain.
module tb_result_drain;

  logic        clk;
  logic        rst;
  logic        cap_valid;
  logic [15:0] c00, c01, c10, c11;
  logic        mode;
  logic        cap_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        host_ack;
  logic        overflow;
  logic        clear_err;

  int n_vec;
  int n_err;
  logic [7:0] exp_q[$];

  result_drain #(.SLOTS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cap_valid (cap_valid),
    .c00       (c00),
    .c01       (c01),
    .c10       (c10),
    .c11       (c11),
    .mode      (mode),
    .cap_ready (cap_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .host_ack  (host_ack),
    .overflow  (overflow),
    .clear_err (clear_err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a tile for one cycle; mode is flipped afterwards to show it is
  // only sampled on the capture edge.
  task automatic capture(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d,
                         input logic m);
    c00 = a; c01 = b; c10 = c; c11 = d; mode = m;
    cap_valid = 1'b1;
    @(negedge clk);
    cap_valid = 1'b0;
    mode = ~m;
  endtask

  // Ack n bytes with host_ack held high, checking each against exp_q.
  // start is the byte index of the first byte, len the tile length.
  // host_ack is left high so consecutive calls drain without a gap.
  task automatic drain(input int n, input int len, input int start, input string tag);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      e = 8'h00;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      check({tag, "_valid"}, 16'(out_valid), 16'd1);
      check({tag, "_data"},  16'(out_data), 16'(e));
      check({tag, "_last"},  16'(out_last), 16'((start + i) == (len - 1)));
      host_ack = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; cap_valid = 1'b0; host_ack = 1'b0; clear_err = 1'b0; mode = 1'b0;
    c00 = 16'h0; c01 = 16'h0; c10 = 16'h0; c11 = 16'h0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_valid", 16'(out_valid), 16'd0);
    check("rst_data",  16'(out_data),  16'h00);
    check("rst_last",  16'(out_last),  16'd0);
    check("rst_ready", 16'(cap_ready), 16'd1);
    check("rst_ovf",   16'(overflow),  16'd0);

    // Raw tile
    capture(16'h1234, 16'h00FF, 16'hFFFE, 16'h0080, 1'b0);
    exp_q = '{8'h34, 8'h12, 8'hFF, 8'h00, 8'hFE, 8'hFF, 8'h80, 8'h00};
    drain(8, 8, 0, "raw");
    host_ack = 1'b0;
    check("raw_empty", 16'(out_valid), 16'd0);

    // Saturated tile
    capture(16'h1234, 16'h0005, 16'hFFFE, 16'hFF00, 1'b1);
    exp_q = '{8'h7F, 8'h05, 8'hFE, 8'h80};
    drain(4, 4, 0, "sat");
    host_ack = 1'b0;
    check("sat_empty", 16'(out_valid), 16'd0);

    // Back-to-back tiles plus dropped capture
    capture(16'h0102, 16'h0304, 16'h0506, 16'h0708, 1'b0);
    check("b2b_ready1", 16'(cap_ready), 16'd1);
    capture(16'h0011, 16'hFF80, 16'h0200, 16'hFFFF, 1'b1);
    check("b2b_ready2", 16'(cap_ready), 16'd0);
    // Drop with clear_err in the same cycle: the set must win
    c00 = 16'h7777; c01 = 16'h7777; c10 = 16'h7777; c11 = 16'h7777;
    cap_valid = 1'b1; clear_err = 1'b1;
    @(negedge clk);
    cap_valid = 1'b0; clear_err = 1'b0;
    check("ovf_set",   16'(overflow),  16'd1);
    check("ovf_ready", 16'(cap_ready), 16'd0);
    exp_q = '{8'h02, 8'h01, 8'h04, 8'h03, 8'h06, 8'h05, 8'h08, 8'h07};
    drain(8, 8, 0, "b2b_a");
    check("b2b_ready_rise", 16'(cap_ready), 16'd1);
    exp_q = '{8'h11, 8'h80, 8'h7F, 8'hFF};
    drain(4, 4, 0, "b2b_b");
    host_ack = 1'b0;
    check("b2b_empty", 16'(out_valid), 16'd0);
    check("ovf_sticky", 16'(overflow), 16'd1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("ovf_clear", 16'(overflow), 16'd0);

    // Capture coinciding with final-byte ack, count = 1
    capture(16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b1);
    exp_q = '{8'h01, 8'h02, 8'h03};
    drain(3, 4, 0, "sim");
    check("sim_last", 16'(out_last), 16'd1);
    check("sim_byte3", 16'(out_data), 16'h04);
    c00 = 16'hABCD; c01 = 16'h0000; c10 = 16'h7FFF; c11 = 16'h8000; mode = 1'b0;
    cap_valid = 1'b1; host_ack = 1'b1;
    @(negedge clk);
    cap_valid = 1'b0; host_ack = 1'b0;
    check("sim_valid", 16'(out_valid), 16'd1);
    check("sim_ready", 16'(cap_ready), 16'd1);
    exp_q = '{8'hCD, 8'hAB, 8'h00, 8'h00, 8'hFF, 8'h7F, 8'h00, 8'h80};
    drain(8, 8, 0, "sim2");
    host_ack = 1'b0;
    check("sim_empty", 16'(out_valid), 16'd0);

    // Stray ack while empty
    host_ack = 1'b1;
    @(negedge clk);
    host_ack = 1'b0;
    check("idle_valid", 16'(out_valid), 16'd0);
    check("idle_data",  16'(out_data),  16'h00);
    check("idle_ready", 16'(cap_ready), 16'd1);
    capture(16'h00AA, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    exp_q = '{8'h7F, 8'h00, 8'h00, 8'h00};
    drain(4, 4, 0, "idle_cap");
    host_ack = 1'b0;

    // Reset mid-drain with both slots full and overflow set
    capture(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);
    capture(16'h5555, 16'h6666, 16'h0000, 16'h0000, 1'b1);
    cap_valid = 1'b1;
    @(negedge clk);
    cap_valid = 1'b0;
    check("rmd_ovf", 16'(overflow), 16'd1);
    exp_q = '{8'h11, 8'h11, 8'h22};
    drain(3, 8, 0, "rmd");
    host_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rmd_valid", 16'(out_valid), 16'd0);
    check("rmd_data",  16'(out_data),  16'h00);
    check("rmd_last",  16'(out_last),  16'd0);
    check("rmd_ready", 16'(cap_ready), 16'd1);
    check("rmd_ovf0",  16'(overflow),  16'd0);
    capture(16'hC3A5, 16'h0F1E, 16'h2D3C, 16'h4B5A, 1'b0);
    exp_q = '{8'hA5, 8'hC3, 8'h1E, 8'h0F, 8'h3C, 8'h2D, 8'h5A, 8'h4B};
    drain(8, 8, 0, "post_rst");
    host_ack = 1'b0;
    check("post_rst_empty", 16'(out_valid), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
